decoder_residual_add: RTL and testbench

DECODER_RESIDUAL_ADD -- requirements
Module: decoder_residual_add

---
 rtl/decoder_residual_add.sv | 130 +++++++++++++
 tb/tb_decoder_residual_add.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_residual_add.sv
// rtl/decoder_residual_add.sv - skip-path FIFO joined with attention stream into a saturating residual sum
// The skip token waits in a small queue until its matching attention token arrives; the pair is summed with clamping.

module residual_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (!push && pop)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Read from registered storage only, so a fresh entry is never visible in its push cycle.
    assign pop_data = mem[rd_ptr];
endmodule

module decoder_residual_add #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   x_valid,
    output logic                   x_ready,
    input  logic [DATA_WIDTH-1:0]  x_data,
    input  logic                   attn_valid,
    output logic                   attn_ready,
    input  logic [DATA_WIDTH-1:0]  attn_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            tok_count,
    output logic [15:0]            sat_count
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic                  push;
    logic                  fire;
    logic                  out_hs;
    logic                  clamp;
    logic [DATA_WIDTH-1:0] x_head;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] result;

    assign x_ready    = !rst && !cfg_start && (fifo_level < FULL_LEVEL);
    assign attn_ready = !rst && !cfg_start && (fifo_level != '0) && (!out_valid || out_ready);
    assign push       = x_valid && x_ready;
    assign fire       = attn_valid && attn_ready;
    assign out_hs     = out_valid && out_ready;

    residual_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (cfg_start),
        .push      (push),
        .push_data (x_data),
        .pop       (fire),
        .pop_data  (x_head),
        .level     (fifo_level)
    );

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum = {attn_data[DATA_WIDTH-1], attn_data} + {x_head[DATA_WIDTH-1], x_head};

    always_comb begin
        clamp  = sum[DATA_WIDTH] != sum[DATA_WIDTH-1];
        result = sum[DATA_WIDTH-1:0];
        if (clamp) result = sum[DATA_WIDTH] ? NEG_MIN : POS_MAX;
    end

    always_ff @(posedge clk) begin
        if (rst || cfg_start) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= result;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cfg_start) begin
            tok_count <= '0;
            sat_count <= '0;
        end else begin
            if (out_hs) tok_count <= tok_count + 16'd1;
            if (fire && clamp && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_decoder_residual_add.sv
// tb/tb_decoder_residual_add.sv - directed and randomized bench for decoder_residual_add
module tb_decoder_residual_add;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, cfg_start;
    logic          x_valid, x_ready, attn_valid, attn_ready, out_valid, out_ready;
    logic [DW-1:0] x_data, attn_data, out_data;
    logic [3:0]    fifo_level;
    logic [15:0]   tok_count, sat_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_xq[$];
    bit          m_ov;
    logic [15:0] m_od;
    int          m_tok, m_sat;

    decoder_residual_add #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .attn_valid(attn_valid), .attn_ready(attn_ready), .attn_data(attn_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fifo_level(fifo_level), .tok_count(tok_count), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    function automatic int ref_raw(input logic [15:0] a, input logic [15:0] b);
        return int'($signed(a)) + int'($signed(b));
    endfunction

    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = ref_raw(a, b);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic pair(input logic [15:0] x, input logic [15:0] a);
        x_valid = 1'b1; x_data = x;
        tick();
        x_valid = 1'b0; attn_valid = 1'b1; attn_data = a;
        tick();
        attn_valid = 1'b0;
    endtask

    // Leaves three entries queued behind one held output.
    task automatic fill_pending();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1; x_data = 16'(20 + i);
            tick();
        end
        x_valid = 1'b0; attn_valid = 1'b1; attn_data = 16'h0;
        tick();
        attn_valid = 1'b0;
    endtask

    // Advances the reference by one clock edge given the inputs currently driven.
    task automatic model_step();
        bit xr, ar, hs;
        logic [15:0] xh;
        xr = (m_xq.size() < DEPTH) && !cfg_start;
        ar = (m_xq.size() > 0) && (!m_ov || out_ready) && !cfg_start;
        if (cfg_start) begin
            m_xq.delete(); m_ov = 0; m_od = 16'h0; m_tok = 0; m_sat = 0;
        end else begin
            hs = m_ov && out_ready;
            if (hs) m_tok = (m_tok + 1) % 65536;
            if (attn_valid && ar) begin
                xh = m_xq.pop_front();
                m_od = ref_sum(attn_data, xh);
                m_ov = 1;
                if ((ref_raw(attn_data, xh) > 32767 || ref_raw(attn_data, xh) < -32768) && m_sat < 65535)
                    m_sat++;
            end else if (hs) begin
                m_ov = 0;
            end
            if (x_valid && xr) m_xq.push_back(x_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 1'b0; x_valid = 1'b1; x_data = 16'h1234;
        attn_valid = 1'b1; attn_data = 16'h1; out_ready = 1'b1;
        tick(); tick();
        n_total++; if (x_ready !== 1'b0) $display("FAIL reset_x_ready: got %b expected 0", x_ready); else n_pass++;
        n_total++; if (attn_ready !== 1'b0) $display("FAIL reset_attn_ready: got %b expected 0", attn_ready); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else n_pass++;
        n_total++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else n_pass++;
        n_total++; if (tok_count !== 16'h0) $display("FAIL reset_tok: got %0d expected 0", tok_count); else n_pass++;
        n_total++; if (sat_count !== 16'h0) $display("FAIL reset_sat: got %0d expected 0", sat_count); else n_pass++;
        rst = 1'b0; x_valid = 1'b0; attn_valid = 1'b0;
        #1;
        n_total++; if (x_ready !== 1'b1) $display("FAIL post_reset_x_ready: got %b expected 1", x_ready); else n_pass++;
    endtask

    task automatic test_basic_sum();
        out_ready = 1'b1;
        x_valid = 1'b1; x_data = 16'h0010;
        tick();
        x_valid = 1'b0; attn_valid = 1'b1; attn_data = 16'h0005;
        #1;
        n_total++; if (attn_ready !== 1'b1) $display("FAIL basic_attn_ready: got %b expected 1", attn_ready); else n_pass++;
        tick();
        attn_valid = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b expected 1", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0015) $display("FAIL basic_out_data: got %h expected 0015", out_data); else n_pass++;
        tick();
        n_total++; if (tok_count !== 16'd1) $display("FAIL basic_tok: got %0d expected 1", tok_count); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_clear: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        flush();
        pair(16'h7000, 16'h2000);
        n_total++; if (out_data !== 16'h7FFF) $display("FAIL pos_sat_data: got %h expected 7fff", out_data); else n_pass++;
        n_total++; if (sat_count !== 16'd1) $display("FAIL pos_sat_count: got %0d expected 1", sat_count); else n_pass++;
        flush();
        pair(16'h8000, 16'hFFFF);
        n_total++; if (out_data !== 16'h8000) $display("FAIL neg_sat_data: got %h expected 8000", out_data); else n_pass++;
        n_total++; if (sat_count !== 16'd1) $display("FAIL neg_sat_count: got %0d expected 1", sat_count); else n_pass++;
        tick();
        pair(16'h7FFF, 16'h8000);
        n_total++; if (out_data !== 16'hFFFF) $display("FAIL no_sat_data: got %h expected ffff", out_data); else n_pass++;
        n_total++; if (sat_count !== 16'd1) $display("FAIL no_sat_count: got %0d expected 1", sat_count); else n_pass++;
    endtask

    task automatic test_full_ordering();
        flush();
        out_ready = 1'b1; attn_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            x_valid = 1'b1; x_data = 16'(i);
            tick();
        end
        x_data = 16'd9;
        #1;
        n_total++; if (fifo_level !== 4'd8) $display("FAIL full_level: got %0d expected 8", fifo_level); else n_pass++;
        n_total++; if (x_ready !== 1'b0) $display("FAIL full_x_ready: got %b expected 0", x_ready); else n_pass++;
        attn_valid = 1'b1; attn_data = 16'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) x_valid = 1'b0;
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 16'(k))
                $display("FAIL order_%0d: got valid %b data %h expected valid 1 data %h", k, out_valid, out_data, 16'(k));
            else n_pass++;
            n_total++;
            if (fifo_level !== 4'(8 - k)) $display("FAIL drain_level_%0d: got %0d expected %0d", k, fifo_level, 8 - k);
            else n_pass++;
        end
        #1;
        n_total++; if (attn_ready !== 1'b0) $display("FAIL empty_attn_ready: got %b expected 0", attn_ready); else n_pass++;
        attn_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        flush();
        out_ready = 1'b1;
        x_valid = 1'b1; x_data = 16'h0003; attn_valid = 1'b1; attn_data = 16'h0004;
        #1;
        n_total++; if (attn_ready !== 1'b0) $display("FAIL no_bypass_attn_ready: got %b expected 0", attn_ready); else n_pass++;
        n_total++; if (x_ready !== 1'b1) $display("FAIL empty_x_ready: got %b expected 1", x_ready); else n_pass++;
        tick();
        x_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_total++; if (attn_ready !== 1'b1) $display("FAIL next_cycle_attn_ready: got %b expected 1", attn_ready); else n_pass++;
        tick();
        x_valid = 1'b1; x_data = 16'h0009;
        tick();
        x_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 16'h0007 || attn_ready !== 1'b0 || fifo_level !== 4'd1)
                $display("FAIL hold_%0d: got v%b d%h ar%b lvl%0d expected v1 d0007 ar0 lvl1",
                         i, out_valid, out_data, attn_ready, fifo_level);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_total++; if (attn_ready !== 1'b1) $display("FAIL release_attn_ready: got %b expected 1", attn_ready); else n_pass++;
        tick();
        attn_valid = 1'b0;
        n_total++; if (out_data !== 16'h000D) $display("FAIL b2b_data: got %h expected 000d", out_data); else n_pass++;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_clear: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (tok_count !== 16'd2) $display("FAIL bp_tok: got %0d expected 2", tok_count); else n_pass++;
    endtask

    task automatic test_flush();
        flush();
        out_ready = 1'b1;
        pair(16'h0001, 16'h0001);
        tick();
        fill_pending();
        n_total++;
        if (fifo_level !== 4'd3 || out_valid !== 1'b1 || tok_count !== 16'd1)
            $display("FAIL pre_flush: got lvl%0d v%b tok%0d expected lvl3 v1 tok1", fifo_level, out_valid, tok_count);
        else n_pass++;
        cfg_start = 1'b1; x_valid = 1'b1; attn_valid = 1'b1; out_ready = 1'b0;
        #1;
        n_total++; if (x_ready !== 1'b0 || attn_ready !== 1'b0)
            $display("FAIL flush_readies: got x%b a%b expected 0 0", x_ready, attn_ready); else n_pass++;
        tick();
        cfg_start = 1'b0; x_valid = 1'b0; attn_valid = 1'b0;
        n_total++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0 || tok_count !== 16'd0 || sat_count !== 16'd0)
            $display("FAIL flush_state: got lvl%0d v%b tok%0d sat%0d expected all 0", fifo_level, out_valid, tok_count, sat_count);
        else n_pass++;
        out_ready = 1'b1;
        pair(16'h0002, 16'h0002);
        tick();
        fill_pending();
        rst = 1'b1; x_valid = 1'b1; attn_valid = 1'b1;
        #1;
        n_total++; if (x_ready !== 1'b0 || attn_ready !== 1'b0)
            $display("FAIL rst_readies: got x%b a%b expected 0 0", x_ready, attn_ready); else n_pass++;
        tick();
        rst = 1'b0; x_valid = 1'b0; attn_valid = 1'b0;
        n_total++;
        if (fifo_level !== 4'd0 || out_valid !== 1'b0 || out_data !== 16'h0 || tok_count !== 16'd0 || sat_count !== 16'd0)
            $display("FAIL rst_state: got lvl%0d v%b d%h tok%0d sat%0d expected all 0",
                     fifo_level, out_valid, out_data, tok_count, sat_count);
        else n_pass++;
    endtask

    task automatic test_random();
        flush();
        m_xq.delete(); m_ov = 0; m_od = 16'h0; m_tok = 0; m_sat = 0;
        for (int c = 0; c < 400; c++) begin
            cfg_start  = ($urandom_range(0, 49) == 0);
            x_valid    = ($urandom_range(0, 9) < 6);
            attn_valid = ($urandom_range(0, 9) < 6);
            out_ready  = ($urandom_range(0, 9) < 7);
            x_data     = 16'($urandom);
            attn_data  = 16'($urandom);
            #1;
            n_total++;
            if (x_ready !== ((m_xq.size() < DEPTH) && !cfg_start) ||
                attn_ready !== ((m_xq.size() > 0) && (!m_ov || out_ready) && !cfg_start))
                $display("FAIL rand_ready_%0d: got x%b a%b with model lvl%0d ov%b", c, x_ready, attn_ready, m_xq.size(), m_ov);
            else n_pass++;
            n_total++;
            if (out_valid !== m_ov || out_data !== m_od || fifo_level !== 4'(m_xq.size()))
                $display("FAIL rand_out_%0d: got v%b d%h lvl%0d expected v%b d%h lvl%0d",
                         c, out_valid, out_data, fifo_level, m_ov, m_od, m_xq.size());
            else n_pass++;
            n_total++;
            if (tok_count !== 16'(m_tok) || sat_count !== 16'(m_sat))
                $display("FAIL rand_cnt_%0d: got tok%0d sat%0d expected tok%0d sat%0d", c, tok_count, sat_count, m_tok, m_sat);
            else n_pass++;
            model_step();
            tick();
        end
        cfg_start = 1'b0; x_valid = 1'b0; attn_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_saturation();
        test_full_ordering();
        test_backpressure();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
